fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0, is the PC value loaded on reset.
REQ-002 Parameter PC_LIMIT, default 32'h1C, is the last valid word address of instruction memory.
REQ-003 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port pc_o, output, 32: fetch address driven to instruction memory Din.
REQ-006 Port inst_i, input, 32: instruction from instruction memory Dout, valid combinationally in the same cycle as pc_o.
REQ-007 Port redirect_valid, input, 1: branch/jump redirect request.
REQ-008 Port redirect_pc, input, 32: redirect target address.
REQ-009 Port halt_i, input, 1: suspends new fetches while high.
REQ-010 Port id_ready, input, 1: decode stage accepts the IF/ID entry this cycle.
REQ-011 Port if_valid, output, 1: IF/ID entry holds a valid instruction.
REQ-012 Port if_inst, output, 32: fetched instruction.
REQ-013 Port if_pc, output, 32: address of if_inst.
REQ-014 Port misalign_err, output, 1: sticky flag for a misaligned redirect.
REQ-015 Port fetch_count, output, 16: number of completed fetches.

Function
REQ-016 FSM states: IDLE, RUN, HALT.
- IDLE -> RUN on the first clock edge after reset release.
- RUN -> HALT when halt_i=1.
- HALT -> RUN when halt_i=0.
REQ-017 pc_o shall equal the PC register; there is no fetch latency beyond the combinational memory read.
REQ-018 A fetch fires when state=RUN, halt_i=0, redirect_valid=0 and (if_valid=0 or id_ready=1).
- On a fetch: if_inst<=inst_i; if_pc<=PC; if_valid<=1; PC<=PC+4.
REQ-019 Stall: when if_valid=1 and id_ready=0, PC, if_inst, if_pc and if_valid shall hold.
REQ-020 When if_valid=1, id_ready=1 and no fetch fires, if_valid<=0.
REQ-021 Redirect has priority over fetch and stall in any state other than IDLE.
- PC<={redirect_pc[31:2],2'b00}.
- if_valid<=0 (flush) in the same edge.
- The first fetch from the new PC occurs on the next cycle.
REQ-022 redirect_valid=1 with redirect_pc[1:0]!=0 shall set misalign_err=1; it stays set until reset.
REQ-023 Simultaneous redirect and halt_i: the PC is redirected, if_valid is flushed, and the state becomes HALT.
REQ-024 In HALT no fetch fires, but a pending if_valid entry drains normally via id_ready.
REQ-025 fetch_count increments by 1 per fetch and saturates at 16'hFFFF.
REQ-026 PC arithmetic is modulo 2^32.

Reset
REQ-027 While rst_n=0, the block is asynchronously held at:
- state=IDLE; PC=PC_RESET (pc_o=PC_RESET).
- if_valid=0, if_inst=0, if_pc=0.
- misalign_err=0, fetch_count=0.
REQ-028 Reset asserted mid-stall or mid-redirect discards all pending state; no fetch fires in the first cycle after release.

Configuration
REQ-029 Macro FETCH_WRAP_EN:
- Defined: a fetch at PC=PC_LIMIT loads PC<=PC_RESET instead of PC+4.
- Undefined: the PC always advances by 4 with no wrap.

Structure
REQ-030 Shared package fetch_pkg holds the FSM state enum (IDLE/RUN/HALT), the instruction width constant (32), and the PC increment constant (4).
REQ-031 One sub-module, if_id_reg, holds the IF/ID register (valid/inst/pc with hold and flush controls).

Verification
REQ-032 Memory preloaded 0x0:15, 0x4:61, 0x8:23, 0xC:81; id_ready=1; release reset:
- Cycle 1: if_valid=0.
- Then if_inst=15,61,23,81 with if_pc=0,4,8,C on consecutive cycles.
REQ-033 id_ready=0 for 3 cycles after the first fetch: if_inst=15 and pc_o=4 hold for 3 cycles; the next fetch returns 61.
REQ-034 redirect_valid=1, redirect_pc=0x9 while pc_o=4:
- Next cycle: pc_o=8, if_valid=0, misalign_err=1.
- Following cycle: if_inst=23.
REQ-035 FETCH_WRAP_EN defined, PC_LIMIT=0x1C, run 9 fetches: the 9th has if_pc=0x0 and if_inst=15. FETCH_WRAP_EN undefined: the 9th has if_pc=0x20.
REQ-036 halt_i=1 together with redirect_pc=0xC:
- State becomes HALT, pc_o=C, and no fetch occurs while halted.
- After halt_i=0: if_inst=81 and fetch_count increments by 1.
REQ-037 rst_n=0 asserted during a stall: pc_o=0, if_valid=0 and fetch_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int          INST_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/inst/pc with load, flush and drain controls.
`timescale 1ns/1ps
module if_id_reg
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              drain,
    input  logic [INST_W-1:0] inst_d,
    input  logic [31:0]       pc_d,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc
);

    // Flush beats load beats drain; with none asserted the entry holds (stall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_d;
            pc    <= pc_d;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/RUN/HALT control, redirect, fetch counter.
// Optional build macro FETCH_WRAP_EN: a fetch at PC_LIMIT reloads PC_RESET.
`timescale 1ns/1ps
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter logic [31:0] PC_LIMIT = 32'h1C
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       pc_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_i,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [31:0]       if_pc,
    output logic              misalign_err,
    output logic [15:0]       fetch_count
);

`ifdef FETCH_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fire, redirect_act, drain;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return (WRAP && pc == PC_LIMIT) ? PC_RESET : pc + PC_INC;
    endfunction

    // Redirects are ignored in IDLE so the first post-reset cycle stays quiet.
    assign redirect_act = redirect_valid && (state_q != IDLE);
    assign fire  = (state_q == RUN) && !halt_i && !redirect_valid && (!if_valid || id_ready);
    assign drain = if_valid && id_ready && !fire;
    assign pc_o  = pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt_i)  state_d = HALT;
            HALT:    if (!halt_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_act)
            pc_d = {redirect_pc[31:2], 2'b00};
        else if (fire)
            pc_d = seq_pc(pc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= PC_RESET;
            misalign_err <= 1'b0;
            fetch_count  <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (redirect_act && (redirect_pc[1:0] != 2'b00))
                misalign_err <= 1'b1;
            if (fire)
                fetch_count <= sat_inc(fetch_count);
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (fire),
        .flush  (redirect_act),
        .drain  (drain),
        .inst_d (inst_i),
        .pc_d   (pc_q),
        .valid  (if_valid),
        .inst   (if_inst),
        .pc     (if_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fetch scoreboard and a combinational memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o, inst_i, redirect_pc, if_inst, if_pc;
    logic        redirect_valid, halt_i, id_ready, if_valid, misalign_err;
    logic [15:0] fetch_count;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;
    fetch_t sb[$];

`ifdef FETCH_WRAP_EN
    localparam logic [31:0] NINTH_PC = 32'h0;
`else
    localparam logic [31:0] NINTH_PC = 32'h20;
`endif

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h15;
            32'h4:   return 32'h61;
            32'h8:   return 32'h23;
            32'hC:   return 32'h81;
            default: return 32'hA500_0000 | a;
        endcase
    endfunction

    assign inst_i = mem_rd(pc_o);

    fetch_unit #(.PC_RESET(32'h0), .PC_LIMIT(32'h1C)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_o           (pc_o),
        .inst_i         (inst_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_i         (halt_i),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        sb.push_back('{pc: pc, inst: inst});
    endtask

    task automatic expect_fetch(input string tag);
        fetch_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_sb: got empty scoreboard, expected a pending fetch", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
            chk({tag, "_pc"}, if_pc, e.pc);
            chk({tag, "_inst"}, if_inst, e.inst);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_i         = 1'b0;
        id_ready       = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_i         = 1'b0;
        id_ready       = 1'b1;

        // Reset values, then in-order fetch of the preloaded memory
        tick();
        tick();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'd0);
        chk("rst_cnt", {16'b0, fetch_count}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", {31'b0, if_valid}, 32'd0);
        chk("idle_pc", pc_o, 32'h0);
        for (int i = 0; i < 4; i++) push(32'(4 * i), mem_rd(32'(4 * i)));
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_fetch("seq");
        end
        chk("seq_pc", pc_o, 32'h10);
        chk("seq_cnt", {16'b0, fetch_count}, 32'd4);

        // Decode stall holds the entry and the PC
        reset_dut();
        tick();
        push(32'h0, 32'h15);
        push(32'h4, 32'h61);
        tick();
        expect_fetch("stall_first");
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_inst", if_inst, 32'h15);
            chk("stall_pc", pc_o, 32'h4);
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
        end
        id_ready = 1'b1;
        tick();
        expect_fetch("stall_next");
        chk("stall_cnt", {16'b0, fetch_count}, 32'd2);

        // Misaligned redirect: aligned PC, flush, sticky error
        reset_dut();
        tick();
        push(32'h0, 32'h15);
        tick();
        expect_fetch("redir_pre");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h9;
        tick();
        chk("redir_pc", pc_o, 32'h8);
        chk("redir_valid", {31'b0, if_valid}, 32'd0);
        chk("redir_mis", {31'b0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        push(32'h8, 32'h23);
        tick();
        expect_fetch("redir_post");
        chk("redir_mis_sticky", {31'b0, misalign_err}, 32'd1);
        chk("redir_cnt", {16'b0, fetch_count}, 32'd2);

        // Nine fetches across PC_LIMIT
        reset_dut();
        tick();
        for (int i = 0; i < 8; i++) push(32'(4 * i), mem_rd(32'(4 * i)));
        push(NINTH_PC, mem_rd(NINTH_PC));
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_fetch("wrap");
        end
        chk("wrap_cnt", {16'b0, fetch_count}, 32'd9);

        // Halt drains a pending entry without fetching
        reset_dut();
        tick();
        push(32'h0, 32'h15);
        tick();
        expect_fetch("halt_pre");
        id_ready = 1'b0;
        halt_i   = 1'b1;
        tick();
        chk("halt_hold_valid", {31'b0, if_valid}, 32'd1);
        chk("halt_hold_inst", if_inst, 32'h15);
        chk("halt_hold_pc", pc_o, 32'h4);
        id_ready = 1'b1;
        tick();
        chk("halt_drain_valid", {31'b0, if_valid}, 32'd0);
        chk("halt_drain_pc", pc_o, 32'h4);
        chk("halt_drain_cnt", {16'b0, fetch_count}, 32'd1);
        halt_i = 1'b0;
        tick();
        chk("halt_exit_valid", {31'b0, if_valid}, 32'd0);
        push(32'h4, 32'h61);
        tick();
        expect_fetch("halt_resume");

        // Redirect together with halt
        halt_i         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        tick();
        chk("rh_pc", pc_o, 32'hC);
        chk("rh_valid", {31'b0, if_valid}, 32'd0);
        chk("rh_mis", {31'b0, misalign_err}, 32'd0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rh_hold_pc", pc_o, 32'hC);
            chk("rh_hold_valid", {31'b0, if_valid}, 32'd0);
            chk("rh_hold_cnt", {16'b0, fetch_count}, 32'd2);
        end
        halt_i = 1'b0;
        tick();
        chk("rh_exit_valid", {31'b0, if_valid}, 32'd0);
        push(32'hC, 32'h81);
        tick();
        expect_fetch("rh_resume");
        chk("rh_cnt", {16'b0, fetch_count}, 32'd3);

        // Asynchronous reset during a stall
        reset_dut();
        tick();
        push(32'h0, 32'h15);
        tick();
        expect_fetch("ar_pre");
        id_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc_o, 32'h0);
        chk("ar_valid", {31'b0, if_valid}, 32'd0);
        chk("ar_cnt", {16'b0, fetch_count}, 32'd0);
        chk("ar_inst", if_inst, 32'h0);
        id_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_first_valid", {31'b0, if_valid}, 32'd0);
        chk("ar_first_cnt", {16'b0, fetch_count}, 32'd0);
        push(32'h0, 32'h15);
        tick();
        expect_fetch("ar_post");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
